// File: rtl/ce_pkg.sv
// ---------------------------------------------------------------------------
// ce_pkg
// Shared definitions for the RS least-squares channel estimator:
//   - ce_state_e : framing FSM states
//   - MAX_FFTPTS : largest packet length accepted at sop
//   - SHIFT_DEF  : default right-shift removing the x65536 RS ROM scaling
//   - fftpts_ok  : legal-length check applied to fftpts_in at sop
// ---------------------------------------------------------------------------
package ce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } ce_state_e;

  localparam int MAX_FFTPTS = 2048;
  localparam int SHIFT_DEF  = 16;

  function automatic logic fftpts_ok(input logic [11:0] n);
    return (n != 12'd0) && (n <= 12'(MAX_FFTPTS));
  endfunction

endpackage

// File: rtl/ce_cmult_conj.sv
// ---------------------------------------------------------------------------
// ce_cmult_conj
// Three-stage pipelined H = Y * conj(X) with round-half-up, arithmetic right
// shift by SHIFT and saturation to wDataOut signed.
//   clk, rst_n      : clock, async active-low reset
//   y_re_i, y_im_i  : received sample (wDataIn signed)
//   x_re_i, x_im_i  : known RS value (wRS signed), same cycle as y
//   ld_i            : loads the output register (valid tag of the sum stage)
//   h_re_o, h_im_o  : registered estimate, holds while ld_i is low
// Stages: products -> re/im sums -> round/shift/saturate into the outputs.
// ---------------------------------------------------------------------------
module ce_cmult_conj
  import ce_pkg::*;
#(
  parameter int wDataIn  = 16,
  parameter int wRS      = 18,
  parameter int wDataOut = 18,
  parameter int SHIFT    = SHIFT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [wDataIn-1:0]  y_re_i,
  input  logic signed [wDataIn-1:0]  y_im_i,
  input  logic signed [wRS-1:0]      x_re_i,
  input  logic signed [wRS-1:0]      x_im_i,
  input  logic                       ld_i,
  output logic signed [wDataOut-1:0] h_re_o,
  output logic signed [wDataOut-1:0] h_im_o
);

  localparam int WP = wDataIn + wRS;   // product width
  localparam int WS = WP + 1;          // sum width
  localparam int WR = WS + 1;          // headroom for the rounding constant

  localparam logic signed [WR-1:0] RND     = WR'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [WR-1:0] SAT_MAX = WR'((64'sd1 <<< (wDataOut - 1)) - 64'sd1);
  localparam logic signed [WR-1:0] SAT_MIN = WR'(-(64'sd1 <<< (wDataOut - 1)));

  logic signed [WP-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic signed [WS-1:0] re_q, im_q;
  logic signed [wDataOut-1:0] h_re_d, h_im_d;

  function automatic logic signed [wDataOut-1:0] rnd_sat(input logic signed [WS-1:0] v);
    logic signed [WR-1:0] r;
    logic signed [wDataOut-1:0] res;
    r = $signed({v[WS-1], v}) + RND;
    r = r >>> SHIFT;
    if (r > SAT_MAX) begin
      res = SAT_MAX[wDataOut-1:0];
    end else if (r < SAT_MIN) begin
      res = SAT_MIN[wDataOut-1:0];
    end else begin
      res = r[wDataOut-1:0];
    end
    return res;
  endfunction

  assign h_re_d = rnd_sat(re_q);
  assign h_im_d = rnd_sat(im_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ir_q <= '0;
      p_ri_q <= '0;
      re_q   <= '0;
      im_q   <= '0;
      h_re_o <= '0;
      h_im_o <= '0;
    end else begin
      p_rr_q <= WP'(y_re_i) * WP'(x_re_i);
      p_ii_q <= WP'(y_im_i) * WP'(x_im_i);
      p_ir_q <= WP'(y_im_i) * WP'(x_re_i);
      p_ri_q <= WP'(y_re_i) * WP'(x_im_i);
      // conj(X): re = yr*xr + yi*xi, im = yi*xr - yr*xi
      re_q   <= WS'(p_rr_q) + WS'(p_ii_q);
      im_q   <= WS'(p_ir_q) - WS'(p_ri_q);
      if (ld_i) begin
        h_re_o <= h_re_d;
        h_im_o <= h_im_d;
      end
    end
  end

endmodule

// File: rtl/ce_ls_rs_rx.sv
// ---------------------------------------------------------------------------
// ce_ls_rs_rx
// Receive-side LS channel estimator for the RS symbol. Frames the incoming
// RS packet, requests the known RS sequence from the generator, and streams
// H = Y * conj(X) / 65536 (rounded, saturated) with 4 clk latency.
//   clk, rst_n               : clock, async active-low reset
//   sink_valid/sop/eop       : received sample framing
//   sink_real/imag           : received sample (wDataIn signed)
//   fftpts_in                : expected packet length, sampled at sop
//   rs_req                   : generator request (combinational, = accepted)
//   rs_real/imag             : generator output, 1 clk after rs_req
//   source_valid/sop/eop     : estimate framing
//   source_real/imag         : LS estimate (wDataOut signed)
//   err                      : one-cycle framing error pulse
//
// state | meaning
// IDLE  | waiting for sop with a legal fftpts_in
// RUN   | inside a packet, counting accepted samples
// GAP   | one forced rs_req-low cycle so the generator address rewinds to 0
// ---------------------------------------------------------------------------
module ce_ls_rs_rx
  import ce_pkg::*;
#(
  parameter int wDataIn  = 16,
  parameter int wRS      = 18,
  parameter int wDataOut = 18,
  parameter int SHIFT    = SHIFT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sink_valid,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic signed [wDataIn-1:0]  sink_real,
  input  logic signed [wDataIn-1:0]  sink_imag,
  input  logic [11:0]                fftpts_in,
  output logic                       rs_req,
  input  logic signed [wRS-1:0]      rs_real,
  input  logic signed [wRS-1:0]      rs_imag,
  output logic                       source_valid,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic signed [wDataOut-1:0] source_real,
  output logic signed [wDataOut-1:0] source_imag,
  output logic                       err
);

  ce_state_e   state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] cnt_q, cnt_d;   // index of the last accepted sample
  logic [11:0] cur_idx;
  logic        run_last, idle_last, fft_ok;
  logic        acc, err_d, eop_ok;
  logic        err_q;

  logic signed [wDataIn-1:0] y_re_q, y_im_q;
  logic vld1_q, vld2_q, vld3_q, vld4_q;
  logic sop1_q, sop2_q, sop3_q, sop4_q;
  logic eop1_q, eop2_q, eop3_q, eop4_q;

  assign cur_idx   = cnt_q + 12'd1;
  assign run_last  = (cur_idx == len_q - 12'd1);
  assign idle_last = (fftpts_in == 12'd1);
  assign fft_ok    = fftpts_ok(fftpts_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sink_valid && sink_sop) begin
          if (fft_ok) begin
            len_d   = fftpts_in;
            cnt_d   = '0;
            state_d = (sink_eop || idle_last) ? ST_GAP : ST_RUN;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_RUN: begin
        if (!sink_valid || sink_sop) begin
          state_d = ST_GAP;
        end else begin
          cnt_d = cur_idx;
          if (sink_eop || run_last) state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A packet ends cleanly only when eop and the last expected index coincide;
  // either one without the other is a framing error, but the sample is kept.
  always_comb begin
    acc    = 1'b0;
    err_d  = 1'b0;
    eop_ok = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sink_valid && sink_sop) begin
          if (fft_ok) begin
            acc = 1'b1;
            if (sink_eop != idle_last) err_d  = 1'b1;
            else if (sink_eop)         eop_ok = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!sink_valid || sink_sop) begin
          err_d = 1'b1;
        end else begin
          acc = 1'b1;
          if (sink_eop != run_last) err_d  = 1'b1;
          else if (sink_eop)        eop_ok = 1'b1;
        end
      end
      ST_GAP: begin
        if (sink_valid && sink_sop) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign rs_req = sink_valid & acc;

  // Tag pipeline; S1 also holds Y so it lines up with rs_real/imag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_re_q <= '0;
      y_im_q <= '0;
      vld1_q <= 1'b0; vld2_q <= 1'b0; vld3_q <= 1'b0; vld4_q <= 1'b0;
      sop1_q <= 1'b0; sop2_q <= 1'b0; sop3_q <= 1'b0; sop4_q <= 1'b0;
      eop1_q <= 1'b0; eop2_q <= 1'b0; eop3_q <= 1'b0; eop4_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (acc) begin
        y_re_q <= sink_real;
        y_im_q <= sink_imag;
      end
      vld1_q <= acc;
      sop1_q <= acc & (state_q == ST_IDLE);
      eop1_q <= acc & eop_ok;
      vld2_q <= vld1_q; sop2_q <= sop1_q; eop2_q <= eop1_q;
      vld3_q <= vld2_q; sop3_q <= sop2_q; eop3_q <= eop2_q;
      vld4_q <= vld3_q;
      sop4_q <= vld3_q & sop3_q;
      eop4_q <= vld3_q & eop3_q;
      err_q  <= err_d;
    end
  end

  ce_cmult_conj #(
    .wDataIn  (wDataIn),
    .wRS      (wRS),
    .wDataOut (wDataOut),
    .SHIFT    (SHIFT)
  ) u_cmult (
    .clk    (clk),
    .rst_n  (rst_n),
    .y_re_i (y_re_q),
    .y_im_i (y_im_q),
    .x_re_i (rs_real),
    .x_im_i (rs_imag),
    .ld_i   (vld3_q),
    .h_re_o (source_real),
    .h_im_o (source_imag)
  );

  assign source_valid = vld4_q;
  assign source_sop   = sop4_q;
  assign source_eop   = eop4_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ce_ls_rs_rx.sv
module tb_ce_ls_rs_rx;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sink_valid, sink_sop, sink_eop;
  logic signed [15:0] sink_real, sink_imag;
  logic [11:0]        fftpts_in;
  logic               rs_req;
  logic signed [17:0] rs_real, rs_imag;
  logic               source_valid, source_sop, source_eop;
  logic signed [17:0] source_real, source_imag;
  logic               err;

  always #5 clk = ~clk;

  ce_ls_rs_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .fftpts_in    (fftpts_in),
    .rs_req       (rs_req),
    .rs_real      (rs_real),
    .rs_imag      (rs_imag),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .err          (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RS generator model: address advances while requested, rewinds when idle.
  logic signed [17:0] gx_re [0:2047];
  logic signed [17:0] gx_im [0:2047];
  logic [10:0]        gaddr = '0;
  initial begin
    rs_real = '0;
    rs_imag = '0;
  end
  always @(posedge clk) begin
    if (rs_req) begin
      rs_real <= gx_re[gaddr];
      rs_imag <= gx_im[gaddr];
      gaddr   <= gaddr + 11'd1;
    end else begin
      gaddr <= '0;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // H = Y*conj(X)/65536, rounded half up, clamped to 18-bit signed.
  function automatic longint clamp18(input longint v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic void ls_model(input longint yr, input longint yi,
                                   input longint xr, input longint xi,
                                   output longint hr, output longint hi);
    longint r, i;
    r  = yr * xr + yi * xi;
    i  = yi * xr - yr * xi;
    hr = clamp18((r + 32768) >>> 16);
    hi = clamp18((i + 32768) >>> 16);
  endfunction

  typedef struct {
    int     cyc;
    longint re;
    longint im;
    bit     sop;
    bit     eop;
  } exp_t;

  exp_t   q[$];
  bit     err_exp [int];
  bit     mon_en = 1'b0;
  longint last_re = 0, last_im = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_re = 0;
      last_im = 0;
    end else if (mon_en) begin
      chk("err", err, err_exp.exists(cyc));
      if (source_valid) begin
        chk("pending_expect", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("real", source_real, e.re);
          chk("imag", source_imag, e.im);
          chk("sop", source_sop, e.sop);
          chk("eop", source_eop, e.eop);
        end
        last_re = source_real;
        last_im = source_imag;
      end else begin
        chk("hold_real", source_real, last_re);
        chk("hold_imag", source_imag, last_im);
        chk("idle_tags", {source_sop, source_eop}, 0);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          chk("missing_output_cycle", cyc, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v, input bit s, input bit e, input int fft,
                      input int yr, input int yi, input bit acc,
                      input bit osop, input bit oeop, input bit eerr,
                      input longint hr, input longint hi);
    exp_t x;
    @(negedge clk);
    sink_valid = v;
    sink_sop   = s;
    sink_eop   = e;
    fftpts_in  = 12'(fft);
    sink_real  = 16'(yr);
    sink_imag  = 16'(yi);
    #1;
    chk("rs_req", rs_req, acc);
    if (acc) begin
      x.cyc = cyc + 4;
      x.re  = hr;
      x.im  = hi;
      x.sop = osop;
      x.eop = oeop;
      q.push_back(x);
    end
    if (eerr) err_exp[cyc + 1] = 1'b1;
  endtask

  task automatic sample(input bit v, input bit s, input bit e, input int fft,
                        input int yr, input int yi, input bit acc, input int idx,
                        input bit osop, input bit oeop, input bit eerr);
    longint hr, hi;
    ls_model(yr, yi, gx_re[idx], gx_im[idx], hr, hi);
    step(v, s, e, fft, yr, yi, acc, osop, oeop, eerr, hr, hi);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_gx(input int n);
    for (int i = 0; i < n; i++) begin
      gx_re[i] = 18'(int'($urandom_range(0, 262143)) - 131072);
      gx_im[i] = 18'(int'($urandom_range(0, 262143)) - 131072);
    end
  endtask

  function automatic int ry();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    sink_valid = 0; sink_sop = 0; sink_eop = 0;
    rst_n = 1'b0;
    q.delete();
    err_exp.delete();
    #1;
    chk("rst_valid", source_valid, 0);
    chk("rst_sop", source_sop, 0);
    chk("rst_eop", source_eop, 0);
    chk("rst_real", source_real, 0);
    chk("rst_imag", source_imag, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int yr, yi, xr, xi, er, ei;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int len;
    sink_valid = 0; sink_sop = 0; sink_eop = 0;
    sink_real = '0; sink_imag = '0; fftpts_in = '0;
    for (int i = 0; i < 2048; i++) begin
      gx_re[i] = '0;
      gx_im[i] = '0;
    end

    repeat (3) @(negedge clk);
    #1;
    chk("reset_valid", source_valid, 0);
    chk("reset_sop", source_sop, 0);
    chk("reset_eop", source_eop, 0);
    chk("reset_real", source_real, 0);
    chk("reset_imag", source_imag, 0);
    chk("reset_err", err, 0);
    chk("reset_rs_req", rs_req, 0);
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Hand-derived vectors: {yr, yi, xr, xi, expected re, expected im}
    tbl[0] = '{1000, 2000, 65536, 0, 1000, 2000};
    tbl[1] = '{1000, 2000, 0, 65536, 2000, -1000};
    tbl[2] = '{32767, 32767, 131071, 131071, 131067, 0};
    tbl[3] = '{-32768, -32768, -131072, -131072, 131071, 0};
    tbl[4] = '{-32768, -32768, -131072, 131071, 1, 131071};
    tbl[5] = '{1, 0, 32768, 0, 1, 0};
    tbl[6] = '{-1, 0, 32768, 0, 0, 0};
    tbl[7] = '{3, 0, -65536, 0, -3, 0};
    tbl[8] = '{0, 7, 0, 65536, 7, 0};
    tbl[9] = '{0, -100, 65536, 65536, -100, -100};
    for (int k = 0; k < 10; k++) begin
      gx_re[k] = 18'(tbl[k].xr);
      gx_im[k] = 18'(tbl[k].xi);
    end
    for (int k = 0; k < 10; k++)
      step(1, k == 0, k == 9, 10, tbl[k].yr, tbl[k].yi, 1, k == 0, k == 9, 0,
           tbl[k].er, tbl[k].ei);
    idle(3);

    // Back-to-back: sop in GAP dropped with err, next sop restarts at address 0
    fill_gx(4);
    for (int k = 0; k < 4; k++) sample(1, k == 0, k == 3, 4, ry(), ry(), 1, k, k == 0, k == 3, 0);
    sample(1, 1, 0, 3, ry(), ry(), 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) sample(1, k == 0, k == 2, 3, ry(), ry(), 1, k, k == 0, k == 2, 0);
    idle(3);

    // sink_valid drops after 5 of 12 samples
    fill_gx(12);
    for (int k = 0; k < 5; k++) sample(1, k == 0, 0, 12, ry(), ry(), 1, k, k == 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Illegal length 0, then single-sample packet
    sample(1, 1, 0, 0, ry(), ry(), 0, 0, 0, 0, 1);
    idle(1);
    sample(1, 1, 1, 1, ry(), ry(), 1, 0, 1, 1, 0);
    idle(3);

    // Length 2049 rejected, 2048 accepted then aborted by sop in RUN
    sample(1, 1, 0, 2049, ry(), ry(), 0, 0, 0, 0, 1);
    idle(1);
    sample(1, 1, 0, 2048, ry(), ry(), 1, 0, 1, 0, 0);
    sample(1, 0, 0, 0, ry(), ry(), 1, 1, 0, 0, 0);
    sample(1, 1, 0, 5, ry(), ry(), 0, 0, 0, 0, 1);
    idle(3);

    // Early eop (len 6, eop on index 3)
    fill_gx(6);
    for (int k = 0; k < 4; k++) sample(1, k == 0, k == 3, 6, ry(), ry(), 1, k, k == 0, 0, k == 3);
    idle(3);

    // Missing eop (len 3, no eop on index 2)
    for (int k = 0; k < 3; k++) sample(1, k == 0, 0, 3, ry(), ry(), 1, k, k == 0, 0, k == 2);
    idle(3);

    // Valid without sop in IDLE and in GAP is dropped silently
    sample(1, 0, 0, 4, ry(), ry(), 0, 0, 0, 0, 0);
    sample(1, 0, 1, 4, ry(), ry(), 0, 0, 0, 0, 0);
    sample(1, 1, 1, 1, ry(), ry(), 1, 0, 1, 1, 0);
    sample(1, 0, 0, 4, ry(), ry(), 0, 0, 0, 0, 0);
    idle(3);

    // Reset mid-packet: nothing from the aborted packet may emerge
    fill_gx(8);
    for (int k = 0; k < 3; k++) sample(1, k == 0, 0, 8, ry(), ry(), 1, k, k == 0, 0, 0);
    do_reset();
    idle(6);

    // Randomised clean packets against the reference model
    for (int p = 0; p < 20; p++) begin
      len = int'($urandom_range(1, 16));
      fill_gx(len);
      for (int k = 0; k < len; k++)
        sample(1, k == 0, k == len - 1, len, ry(), ry(), 1, k, k == 0, k == len - 1, 0);
      idle(int'($urandom_range(1, 3)));
    end

    idle(8);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
